if_parcel_aligner: RTL and testbench
====================================

Name: if_parcel_aligner

Overview:
- Fetch-side halfword aligner sitting directly upstream of the pre-decode stage.
- Consumes a stream of 32-bit word-aligned fetch words and tracks the instruction PC at halfword granularity.
- Registers per-instruction selection signals for the pre-decode stage: raw 16-bit parcel, compressed/spanning/NOP select, spanning instruction, effective instruction, PC and link address.
- Holds the low half of 32-bit instructions that straddle a word boundary until the next word arrives.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h0000_0000, instruction PC loaded on reset (bit 0 must be 0)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-high
i_stall  in  1  pipeline stall; hold all state and outputs
i_flush  in  1  redirect; discard buffered state, load i_redirect_pc
i_redirect_pc  in  XLEN  new instruction PC on flush (bit 0 = 0)
i_word_valid  in  1  fetch word present
i_word_addr  in  XLEN  byte address of fetch word (bits [1:0] = 0)
i_word  in  32  fetch word, little-endian halfwords
o_word_ready  out  1  word consumed this cycle (combinational)
o_raw_parcel  out  16  parcel for RVC decompressor
o_sel_nop  out  1  emit NOP this cycle
o_sel_compressed  out  1  emit decompressed parcel
o_sel_spanning  out  1  emit o_spanning_instr
o_spanning_instr  out  32  {new word[15:0], saved halfword}
o_effective_instr  out  32  aligned 32-bit instruction
o_program_counter  out  XLEN  PC of emitted instruction
o_link_address  out  XLEN  PC+2 (compressed) or PC+4

Behaviour:
- Async reset, active-high. Outputs reset to:
  - o_sel_nop=1; all other selects 0.
  - o_raw_parcel, o_spanning_instr, o_effective_instr = 0.
  - o_program_counter = RESET_PC; o_link_address = RESET_PC+4.
- Internal reset: pc=RESET_PC, state=IDLE_ALIGN, saved_hw=0.
- Reset asserted mid-instruction (including SPAN_WAIT) discards everything.
- Selects are one-hot every cycle. All outputs are registered, so latency is 1 cycle from word acceptance.
- Word match: match = i_word_valid && i_word_addr[XLEN-1:2] == pc[XLEN-1:2], or == pc[XLEN-1:2]+1 in SPAN_WAIT.
- Word with i_word_valid and no match is stale: o_word_ready=1, word dropped, NOP emitted, state unchanged.
- No valid word: o_word_ready=0, NOP emitted, state unchanged.
- Compressed test: parcel[1:0] != 2'b11. The parcel 16'h0000 counts as compressed; illegality is flagged downstream.
- States:
  - IDLE_ALIGN (pc[1]=0), matched word:
    - word[1:0] != 11: sel_compressed, parcel=word[15:0], pc+=2, o_word_ready=0 (upper half still needed) -> HALF.
    - else: sel_32bit (all selects 0), effective_instr=word, pc+=4, ready=1, stay.
  - HALF (pc[1]=1), matched word:
    - word[17:16] != 11: sel_compressed, parcel=word[31:16], pc+=2, ready=1 -> IDLE_ALIGN.
    - else: saved_hw=word[31:16], ready=1, emit NOP -> SPAN_WAIT. pc unchanged.
  - SPAN_WAIT, matched next word: sel_spanning, spanning_instr={word[15:0],saved_hw}, o_program_counter=pc, pc+=4, ready=0 (upper half still needed) -> HALF.
- o_program_counter is always the pre-increment pc; o_link_address = pc+2 (compressed) or pc+4. Both wrap modulo 2^XLEN.
- NOP cycles still update o_program_counter/o_link_address to current pc/pc+4.
- Stall without flush: o_word_ready=0; state, pc, saved_hw and all outputs held.
- Flush (priority over stall and word):
  - pc=i_redirect_pc; state = i_redirect_pc[1] ? HALF : IDLE_ALIGN; saved_hw cleared.
  - Emit NOP; o_word_ready=1 if i_word_valid (word discarded).
- Flush while in SPAN_WAIT abandons the saved halfword; it is never emitted.
- Flush into HALF requires the first matched word to supply word[31:16].

Test Plan:
- Reset release, word @0x0 = 0x00500093 (addi x1,x0,5) -> next cycle sel 32bit, effective_instr=0x00500093, PC=0x0, link=0x4, ready=1.
- Words 0x45014501 @0x0 (two c.li) -> cycle1 compressed parcel 0x4501 PC=0x0 ready=0; cycle2 parcel 0x4501 PC=0x2 link=0x4 ready=1.
- Span: word @0x0 = 0x00934501, word @0x4 = 0x????0050 -> c.li PC=0x0, NOP (saved 0x0093), then sel_spanning spanning_instr=0x00500093 PC=0x2 link=0x6, ready=0, state HALF.
- Flush to 0x102 while in SPAN_WAIT, stall simultaneously asserted -> NOP, saved_hw=0, word @0x100 then yields upper-half parcel with PC=0x102.
- Stale word @0x8 while pc=0x0 -> ready=1, NOP, pc remains 0x0; stall high for 3 cycles mid-sequence -> outputs bit-identical throughout, ready=0.
- Assert i_rst asynchronously (between clock edges) in SPAN_WAIT -> outputs immediately sel_nop=1, PC=RESET_PC; after release first word decoded from RESET_PC.

Source files
------------

// File: rtl/if_parcel_aligner.sv
// Fetch-side halfword aligner: turns word-aligned 32-bit fetch words into
// per-instruction selects (compressed / 32-bit / spanning / NOP) for pre-decode.
module if_parcel_aligner #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_word_valid,
    input  logic [XLEN-1:0] i_word_addr,
    input  logic [31:0]     i_word,
    output logic            o_word_ready,
    output logic [15:0]     o_raw_parcel,
    output logic            o_sel_nop,
    output logic            o_sel_compressed,
    output logic            o_sel_spanning,
    output logic [31:0]     o_spanning_instr,
    output logic [31:0]     o_effective_instr,
    output logic [XLEN-1:0] o_program_counter,
    output logic [XLEN-1:0] o_link_address
);

    localparam logic [XLEN-1:0] PC_INC2 = XLEN'(2);
    localparam logic [XLEN-1:0] PC_INC4 = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE_ALIGN,
        HALF,
        SPAN_WAIT
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [15:0]       saved_hw;

    logic [XLEN-3:0]   word_tag;
    logic [XLEN-3:0]   want_tag;
    logic              word_match;
    logic [15:0]       lo_hw;
    logic [15:0]       hi_hw;
    logic              lo_is_rvc;
    logic              hi_is_rvc;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^i_word_addr[1:0];

    assign lo_hw     = i_word[15:0];
    assign hi_hw     = i_word[31:16];
    assign lo_is_rvc = (lo_hw[1:0] != 2'b11);
    assign hi_is_rvc = (hi_hw[1:0] != 2'b11);
    assign word_tag  = i_word_addr[XLEN-1:2];

    // Which fetch word the aligner needs next: the pc's own word, or the following one while a span is pending
    always_comb begin
        want_tag   = pc[XLEN-1:2];
        if (state == SPAN_WAIT) begin
            want_tag = pc[XLEN-1:2] + 1'b1;
        end
        word_match = i_word_valid && (word_tag == want_tag);
    end

    // Word consumption handshake: a word is held whenever its upper half is still needed
    always_comb begin
        o_word_ready = 1'b0;
        if (i_flush) begin
            o_word_ready = i_word_valid;
        end else if (i_stall || !i_word_valid) begin
            o_word_ready = 1'b0;
        end else if (!word_match) begin
            o_word_ready = 1'b1;
        end else begin
            unique case (state)
                IDLE_ALIGN: o_word_ready = !lo_is_rvc;
                HALF:       o_word_ready = 1'b1;
                SPAN_WAIT:  o_word_ready = 1'b0;
                default:    o_word_ready = 1'b0;
            endcase
        end
    end

    // Alignment FSM with registered pre-decode selects, pc tracking and span buffer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= IDLE_ALIGN;
            pc                <= RESET_PC;
            saved_hw          <= '0;
            o_sel_nop         <= 1'b1;
            o_sel_compressed  <= 1'b0;
            o_sel_spanning    <= 1'b0;
            o_raw_parcel      <= '0;
            o_spanning_instr  <= '0;
            o_effective_instr <= '0;
            o_program_counter <= RESET_PC;
            o_link_address    <= RESET_PC + PC_INC4;
        end else if (i_flush) begin
            pc                <= i_redirect_pc;
            state             <= i_redirect_pc[1] ? HALF : IDLE_ALIGN;
            saved_hw          <= '0;
            o_sel_nop         <= 1'b1;
            o_sel_compressed  <= 1'b0;
            o_sel_spanning    <= 1'b0;
            o_program_counter <= i_redirect_pc;
            o_link_address    <= i_redirect_pc + PC_INC4;
        end else if (!i_stall) begin
            o_sel_nop         <= 1'b1;
            o_sel_compressed  <= 1'b0;
            o_sel_spanning    <= 1'b0;
            o_program_counter <= pc;
            o_link_address    <= pc + PC_INC4;
            if (word_match) begin
                unique case (state)
                    IDLE_ALIGN: begin
                        o_sel_nop <= 1'b0;
                        if (lo_is_rvc) begin
                            o_sel_compressed <= 1'b1;
                            o_raw_parcel     <= lo_hw;
                            o_link_address   <= pc + PC_INC2;
                            pc               <= pc + PC_INC2;
                            state            <= HALF;
                        end else begin
                            o_effective_instr <= i_word;
                            pc                <= pc + PC_INC4;
                        end
                    end
                    HALF: begin
                        if (hi_is_rvc) begin
                            o_sel_nop        <= 1'b0;
                            o_sel_compressed <= 1'b1;
                            o_raw_parcel     <= hi_hw;
                            o_link_address   <= pc + PC_INC2;
                            pc               <= pc + PC_INC2;
                            state            <= IDLE_ALIGN;
                        end else begin
                            saved_hw <= hi_hw;
                            state    <= SPAN_WAIT;
                        end
                    end
                    SPAN_WAIT: begin
                        o_sel_nop        <= 1'b0;
                        o_sel_spanning   <= 1'b1;
                        o_spanning_instr <= {lo_hw, saved_hw};
                        pc               <= pc + PC_INC4;
                        state            <= HALF;
                    end
                    default: state <= IDLE_ALIGN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_parcel_aligner.sv
// Scoreboard bench for if_parcel_aligner: expected emissions are queued when a
// word is driven and popped/compared one cycle later.
`define READY_CHECK(tag, expv) \
    begin \
        checks++; \
        if (o_word_ready !== (expv)) begin \
            errors++; \
            $display("FAIL %s ready: got %0b expected %0b", tag, o_word_ready, (expv)); \
        end \
    end

`define POP_CHECK(tag) \
    begin \
        checks++; \
        if (sb.size() == 0) begin \
            errors++; \
            $display("FAIL %s: scoreboard empty", tag); \
        end else begin \
            cur = sb.pop_front(); \
            if (o_sel_nop !== cur.nop || o_sel_compressed !== cur.comp || o_sel_spanning !== cur.span || \
                (cur.chk_pc && (o_program_counter !== cur.pc || o_link_address !== cur.link)) || \
                (cur.comp && o_raw_parcel !== cur.data[15:0]) || \
                (cur.span && o_spanning_instr !== cur.data) || \
                (!cur.nop && !cur.comp && !cur.span && o_effective_instr !== cur.data)) begin \
                errors++; \
                $display("FAIL %s: got nop=%0b c=%0b s=%0b raw=%h span=%h eff=%h pc=%h link=%h expected nop=%0b c=%0b s=%0b data=%h pc=%h link=%h", \
                         tag, o_sel_nop, o_sel_compressed, o_sel_spanning, o_raw_parcel, o_spanning_instr, \
                         o_effective_instr, o_program_counter, o_link_address, cur.nop, cur.comp, cur.span, \
                         cur.data, cur.pc, cur.link); \
            end \
        end \
    end

module tb_if_parcel_aligner;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_redirect_pc;
    logic        i_word_valid;
    logic [31:0] i_word_addr;
    logic [31:0] i_word;
    logic        o_word_ready;
    logic [15:0] o_raw_parcel;
    logic        o_sel_nop;
    logic        o_sel_compressed;
    logic        o_sel_spanning;
    logic [31:0] o_spanning_instr;
    logic [31:0] o_effective_instr;
    logic [31:0] o_program_counter;
    logic [31:0] o_link_address;

    typedef struct {
        logic        nop;
        logic        comp;
        logic        span;
        logic        chk_pc;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] link;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    if_parcel_aligner #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .i_redirect_pc    (i_redirect_pc),
        .i_word_valid     (i_word_valid),
        .i_word_addr      (i_word_addr),
        .i_word           (i_word),
        .o_word_ready     (o_word_ready),
        .o_raw_parcel     (o_raw_parcel),
        .o_sel_nop        (o_sel_nop),
        .o_sel_compressed (o_sel_compressed),
        .o_sel_spanning   (o_sel_spanning),
        .o_spanning_instr (o_spanning_instr),
        .o_effective_instr(o_effective_instr),
        .o_program_counter(o_program_counter),
        .o_link_address   (o_link_address)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t e_nop(input logic [31:0] pc);
        exp_t e = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, pc, pc + 32'd4};
        return e;
    endfunction

    function automatic exp_t e_nop_nopc();
        exp_t e = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        return e;
    endfunction

    function automatic exp_t e_c(input logic [15:0] p, input logic [31:0] pc);
        exp_t e = '{1'b0, 1'b1, 1'b0, 1'b1, {16'h0, p}, pc, pc + 32'd2};
        return e;
    endfunction

    function automatic exp_t e_32(input logic [31:0] w, input logic [31:0] pc);
        exp_t e = '{1'b0, 1'b0, 1'b0, 1'b1, w, pc, pc + 32'd4};
        return e;
    endfunction

    function automatic exp_t e_sp(input logic [31:0] w, input logic [31:0] pc);
        exp_t e = '{1'b0, 1'b0, 1'b1, 1'b1, w, pc, pc + 32'd4};
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] w,
                          input logic st, input logic fl, input logic [31:0] rpc);
        i_word_valid  = v;
        i_word_addr   = a;
        i_word        = w;
        i_stall       = st;
        i_flush       = fl;
        i_redirect_pc = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        sb.delete();
        i_rst = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_sel_nop !== 1'b1 || o_sel_compressed !== 1'b0 || o_sel_spanning !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel: got nop=%0b c=%0b s=%0b expected 1 0 0", o_sel_nop, o_sel_compressed, o_sel_spanning);
        end
        checks++;
        if (o_raw_parcel !== 16'h0 || o_spanning_instr !== 32'h0 || o_effective_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got raw=%h span=%h eff=%h expected zeros", o_raw_parcel, o_spanning_instr, o_effective_instr);
        end
        checks++;
        if (o_program_counter !== 32'h0 || o_link_address !== 32'h4) begin
            errors++;
            $display("FAIL reset_pc: got pc=%h link=%h expected 0 4", o_program_counter, o_link_address);
        end
        `READY_CHECK("reset_idle", 1'b0)
        sb.push_back(e_nop(32'h0));
        tick();
        `POP_CHECK("reset_idle_nop")
    endtask

    task automatic test_32bit();
        do_reset();
        set_in(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("w32", 1'b1)
        sb.push_back(e_32(32'h0050_0093, 32'h0));
        tick();
        `POP_CHECK("w32")
    endtask

    task automatic test_two_compressed();
        do_reset();
        set_in(1'b1, 32'h0, 32'h4501_4501, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("cc_first", 1'b0)
        sb.push_back(e_c(16'h4501, 32'h0));
        tick();
        `POP_CHECK("cc_first")
        `READY_CHECK("cc_second", 1'b1)
        sb.push_back(e_c(16'h4501, 32'h2));
        tick();
        `POP_CHECK("cc_second")
    endtask

    task automatic test_span();
        do_reset();
        set_in(1'b1, 32'h0, 32'h0093_4501, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("span_c", 1'b0)
        sb.push_back(e_c(16'h4501, 32'h0));
        tick();
        `POP_CHECK("span_c")
        `READY_CHECK("span_save", 1'b1)
        sb.push_back(e_nop(32'h2));
        tick();
        `POP_CHECK("span_save")
        set_in(1'b1, 32'h4, 32'hABCD_0050, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("span_emit", 1'b0)
        sb.push_back(e_sp(32'h0050_0093, 32'h2));
        tick();
        `POP_CHECK("span_emit")
        `READY_CHECK("span_upper", 1'b1)
        sb.push_back(e_c(16'hABCD, 32'h6));
        tick();
        `POP_CHECK("span_upper")
    endtask

    task automatic test_flush_span();
        do_reset();
        set_in(1'b1, 32'h0, 32'h0093_4501, 1'b0, 1'b0, 32'h0);
        sb.push_back(e_c(16'h4501, 32'h0));
        tick();
        `POP_CHECK("fl_c")
        sb.push_back(e_nop(32'h2));
        tick();
        `POP_CHECK("fl_save")
        set_in(1'b1, 32'h4, 32'hABCD_0050, 1'b1, 1'b1, 32'h0000_0102);
        `READY_CHECK("fl_flush", 1'b1)
        sb.push_back(e_nop_nopc());
        tick();
        `POP_CHECK("fl_flush")
        set_in(1'b1, 32'h100, 32'h4581_0093, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("fl_upper", 1'b1)
        sb.push_back(e_c(16'h4581, 32'h102));
        tick();
        `POP_CHECK("fl_upper")
        // pc wraps modulo 2^32 on the link address
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        `READY_CHECK("wrap_flush", 1'b0)
        sb.push_back(e_nop_nopc());
        tick();
        `POP_CHECK("wrap_flush")
        set_in(1'b1, 32'hFFFF_FFFC, 32'h4501_1111, 1'b0, 1'b0, 32'h0);
        sb.push_back(e_c(16'h4501, 32'hFFFF_FFFE));
        tick();
        `POP_CHECK("wrap_c")
        checks++;
        if (o_link_address !== 32'h0) begin
            errors++;
            $display("FAIL wrap_link: got %h expected 00000000", o_link_address);
        end
    endtask

    task automatic test_stale_stall();
        do_reset();
        set_in(1'b1, 32'h8, 32'h4501_4501, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("stale", 1'b1)
        sb.push_back(e_nop(32'h0));
        tick();
        `POP_CHECK("stale")
        set_in(1'b1, 32'h0, 32'h4501_4501, 1'b0, 1'b0, 32'h0);
        sb.push_back(e_c(16'h4501, 32'h0));
        tick();
        `POP_CHECK("stall_pre")
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h0, 32'h4501_4501, 1'b1, 1'b0, 32'h0);
            `READY_CHECK("stall_ready", 1'b0)
            sb.push_back(e_c(16'h4501, 32'h0));
            tick();
            `POP_CHECK("stall_hold")
        end
        set_in(1'b1, 32'h0, 32'h4501_4501, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("stall_post", 1'b1)
        sb.push_back(e_c(16'h4501, 32'h2));
        tick();
        `POP_CHECK("stall_post")
        set_in(1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("novalid", 1'b0)
        sb.push_back(e_nop(32'h4));
        tick();
        `POP_CHECK("novalid")
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        do_reset();
        words[0] = 32'h0000_0013;
        words[1] = 32'hFFF0_8093;
        words[2] = 32'h0020_8133;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(4 * i), words[i], 1'b0, 1'b0, 32'h0);
            `READY_CHECK("b2b_ready", 1'b1)
            sb.push_back(e_32(words[i], 32'(4 * i)));
            tick();
            `POP_CHECK("b2b")
        end
        // all-zero parcel is treated as compressed
        set_in(1'b1, 32'hC, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("zero_parcel", 1'b0)
        sb.push_back(e_c(16'h0000, 32'hC));
        tick();
        `POP_CHECK("zero_parcel")
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(1'b1, 32'h0, 32'h0093_4501, 1'b0, 1'b0, 32'h0);
        sb.push_back(e_c(16'h4501, 32'h0));
        tick();
        `POP_CHECK("ar_c")
        sb.push_back(e_nop(32'h2));
        tick();
        `POP_CHECK("ar_save")
        set_in(1'b1, 32'h4, 32'hABCD_0050, 1'b0, 1'b0, 32'h0);
        #1;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_sel_nop !== 1'b1 || o_sel_spanning !== 1'b0 || o_sel_compressed !== 1'b0 ||
            o_program_counter !== 32'h0 || o_link_address !== 32'h4) begin
            errors++;
            $display("FAIL async_rst: got nop=%0b c=%0b s=%0b pc=%h link=%h expected 1 0 0 0 4",
                     o_sel_nop, o_sel_compressed, o_sel_spanning, o_program_counter, o_link_address);
        end
        tick();
        i_rst = 1'b0;
        set_in(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        `READY_CHECK("ar_after", 1'b1)
        sb.push_back(e_32(32'h0050_0093, 32'h0));
        tick();
        `POP_CHECK("ar_after")
    endtask

    initial begin
        i_rst = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_32bit();
        test_two_compressed();
        test_span();
        test_flush_span();
        test_stale_stall();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
